// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I subset, with memory handshake, wait timeout and a retire counter
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_error,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  state_t st, nxt;
  logic [6:0] op_q;
  logic [7:0] wait_cnt;
  logic r, ld, sw, br, legal, waiting, timeout;
  logic is_f, is_d, is_e, is_m, is_w;
  assign r = op_q == OP_R;
  assign ld = op_q == OP_LD;
  assign sw = op_q == OP_ST;
  assign br = op_q == OP_BR;
  assign legal = Opcode inside {OP_R, OP_LD, OP_ST, OP_BR};
  assign is_f = st == FETCH;
  assign is_d = st == DECODE;
  assign is_e = st == EXEC;
  assign is_m = st == MEM;
  assign is_w = st == WB;
  assign waiting = (is_f || is_m) && !mem_ready;
  assign timeout = waiting && wait_cnt == 8'(WAIT_LIMIT - 1);
  always_comb begin
    nxt = is_f ? (mem_ready ? DECODE : FETCH) :
          is_d ? (legal ? EXEC : FETCH) :
          is_e ? (r ? WB : (ld || sw) ? MEM : FETCH) :
          is_m ? (mem_ready ? (ld ? WB : FETCH) : timeout ? FETCH : MEM) :
          FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      op_q <= '0;
      wait_cnt <= '0;
      retired <= '0;
    end else begin
      st <= nxt;
      if (is_d) op_q <= Opcode;
      wait_cnt <= (waiting && !timeout) ? wait_cnt + 8'd1 : 8'd0;
      if (instr_done) retired <= retired + CNT_W'(1);
    end
  end
  assign state = st;
  assign mem_req = is_f || is_m;
  assign IorD = is_m;
  assign MemRead = is_f || (is_m && ld);
  assign MemWrite = is_m && sw;
  assign IRWrite = is_f && mem_ready;
  assign PCWrite = (is_f && mem_ready) || (is_e && br && Zero);
  assign PCSource = is_e && br;
  assign ALUSrcA = is_e;
  assign ALUSrcB = is_f ? 2'b01 : is_d ? 2'b11 : (is_e && (ld || sw)) ? 2'b10 : 2'b00;
  assign ALUOp = (is_e && r) ? 2'b10 : (is_e && br) ? 2'b01 : 2'b00;
  assign RegWrite = is_w;
  assign MemtoReg = is_w && ld;
  assign instr_done = (is_e && br) || (is_m && sw && mem_ready) || is_w;
  assign illegal_op = is_d && !legal;
  assign mem_error = timeout;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: phase-level reference checks of multicycle_ctrl with directed and random instruction streams
module tb_multicycle_ctrl;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  logic clk = 0, reset = 1, Zero = 0, mem_ready = 0;
  logic [6:0] Opcode = '0;
  logic mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA, RegWrite, MemtoReg;
  logic instr_done, illegal_op, mem_error;
  logic [1:0] ALUSrcB, ALUOp;
  logic [2:0] state;
  logic [15:0] retired;
  logic w_mreq, w_iord, w_mrd, w_mwr, w_irw, w_pcw, w_pcs, w_asa, w_rw, w_m2r, w_done, w_ill, w_err;
  logic [1:0] w_asb, w_aop;
  logic [2:0] w_st;
  logic [3:0] retired_w;
  int n_asrt = 0, n_fail = 0, exp_ret = 0;
  logic e_mreq, e_iord, e_mrd, e_mwr, e_irw, e_pcw, e_pcs, e_asa, e_rw, e_m2r, e_done, e_ill, e_err;
  logic [1:0] e_asb, e_aop;
  logic [2:0] e_st;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_error(mem_error), .retired(retired)
  );

  multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) u_w (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(w_mreq), .IorD(w_iord), .MemRead(w_mrd), .MemWrite(w_mwr), .IRWrite(w_irw),
    .PCWrite(w_pcw), .PCSource(w_pcs), .ALUSrcA(w_asa), .ALUSrcB(w_asb), .ALUOp(w_aop),
    .RegWrite(w_rw), .MemtoReg(w_m2r), .state(w_st), .instr_done(w_done),
    .illegal_op(w_ill), .mem_error(w_err), .retired(retired_w)
  );

  task automatic idle(input logic [2:0] st);
    {e_mreq, e_iord, e_mrd, e_mwr, e_irw, e_pcw, e_pcs, e_asa, e_rw, e_m2r, e_done, e_ill, e_err} = '0;
    e_asb = 2'b00;
    e_aop = 2'b00;
    e_st = st;
  endtask

  task automatic chk(input string tag);
    logic [19:0] o, e;
    o = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp,
         RegWrite, MemtoReg, state, instr_done, illegal_op, mem_error};
    e = {e_mreq, e_iord, e_mrd, e_mwr, e_irw, e_pcw, e_pcs, e_asa, e_asb, e_aop,
         e_rw, e_m2r, e_st, e_done, e_ill, e_err};
    n_asrt++;
    assert (o === e) else begin n_fail++; $error("FAIL %s ctrl observed=%h expected=%h", tag, o, e); end
    n_asrt++;
    assert (retired === 16'(exp_ret)) else begin n_fail++; $error("FAIL %s retired observed=%h expected=%h", tag, retired, 16'(exp_ret)); end
    n_asrt++;
    assert (retired_w === 4'(exp_ret)) else begin n_fail++; $error("FAIL %s retired4 observed=%h expected=%h", tag, retired_w, 4'(exp_ret)); end
    if (e_done) exp_ret++;
  endtask

  task automatic cyc(input logic rdy, input logic [6:0] op, input logic z);
    @(negedge clk);
    reset = 0;
    mem_ready = rdy;
    Opcode = op;
    Zero = z;
    #1;
  endtask

  function automatic logic [6:0] noise();
    return 7'($urandom);
  endfunction

  task automatic fetch_outs(input logic rdy);
    idle(3'd0);
    e_mreq = 1;
    e_mrd = 1;
    e_asb = 2'b01;
    e_irw = rdy;
    e_pcw = rdy;
  endtask

  task automatic mem_outs(input logic ld, input logic sw);
    idle(3'd3);
    e_mreq = 1;
    e_iord = 1;
    e_mrd = ld;
    e_mwr = sw;
  endtask

  // fw/mw: not-ready cycles before ready in FETCH/MEM; every 4th consecutive one times out
  task automatic run(input logic [6:0] op, input logic z, input int fw, input int mw, input bit rst_mem = 0);
    bit r, ld, sw, br;
    r = op == OP_R;
    ld = op == OP_LD;
    sw = op == OP_ST;
    br = op == OP_BR;
    for (int i = 0; i < fw; i++) begin
      cyc(0, noise(), 1'($urandom));
      fetch_outs(0);
      e_err = (i % 4) == 3;
      chk("fetch_wait");
    end
    cyc(1, noise(), 1'($urandom));
    fetch_outs(1);
    chk("fetch");
    cyc(1'($urandom), op, 1'($urandom));
    idle(3'd1);
    e_asb = 2'b11;
    e_ill = !(r || ld || sw || br);
    chk("decode");
    if (e_ill) return;
    cyc(1'($urandom), noise(), z);
    idle(3'd2);
    e_asa = 1;
    e_asb = (ld || sw) ? 2'b10 : 2'b00;
    e_aop = r ? 2'b10 : br ? 2'b01 : 2'b00;
    e_pcs = br;
    e_pcw = br && z;
    e_done = br;
    chk("exec");
    if (br) return;
    if (ld || sw) begin
      if (rst_mem) begin
        cyc(0, noise(), 1'($urandom));
        reset = 1;
        mem_outs(ld, sw);
        chk("mem_before_reset");
        exp_ret = 0;
        cyc(0, noise(), 1'($urandom));
        reset = 1;
        fetch_outs(0);
        chk("after_reset");
        n_asrt++;
        assert (dut.op_q === 7'd0) else begin n_fail++; $error("FAIL op_q_reset observed=%h expected=00", dut.op_q); end
        return;
      end
      for (int i = 0; i < mw; i++) begin
        cyc(0, noise(), 1'($urandom));
        mem_outs(ld, sw);
        e_err = i == 3;
        chk("mem_wait");
        if (e_err) return;
      end
      cyc(1, noise(), 1'($urandom));
      mem_outs(ld, sw);
      e_done = sw;
      chk("mem");
      if (sw) return;
    end
    cyc(1'($urandom), noise(), 1'($urandom));
    idle(3'd4);
    e_rw = 1;
    e_m2r = ld;
    e_done = 1;
    chk("wb");
  endtask

  initial begin
    logic [6:0] ops [5];
    ops = '{OP_R, OP_LD, OP_ST, OP_BR, 7'b0010011};
    repeat (2) @(negedge clk);
    #1;
    n_asrt++;
    assert (state === 3'd0 && retired === 16'd0) else begin n_fail++; $error("FAIL reset_state observed=%0d/%h expected=0/0000", state, retired); end
    run(OP_R, 0, 0, 0);
    run(OP_LD, 0, 3, 2);
    run(OP_ST, 0, 0, 0);
    run(OP_BR, 1, 0, 0);
    run(OP_BR, 0, 0, 0);
    run(7'b0010011, 0, 0, 0);
    run(OP_LD, 0, 0, 4);
    run(OP_LD, 0, 0, 3);
    run(OP_R, 0, 9, 0);
    run(OP_ST, 0, 2, 5);
    run(OP_ST, 0, 1, 0, 1);
    for (int k = 0; k < 20; k++) run(OP_BR, 1'($urandom), 0, 0);
    for (int k = 0; k < 200; k++)
      run(ops[$urandom_range(0, 4)], 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
    run(OP_ST, 0, 0, 1, 1);
    run(OP_R, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
